head_sram_wr_ctrl: RTL
======================

HEAD_SRAM_WR_CTRL -- requirements
Module: head_sram_wr_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  clock; all state on rising edge.
REQ-002 SHALL expose: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL expose: control_state  in  CONTROL_STATE  layer phase; sampled when control_state_update=1.
REQ-004 SHALL expose: control_state_update  in  1  load strobe for control_state.
REQ-005 SHALL expose: model_cfg_vld  in  1 and model_cfg  in  MODEL_CONFIG  registered when model_cfg_vld=1.
REQ-006 SHALL expose: start  in  1  one-cycle pulse opening a write pass for the registered state.
REQ-007 SHALL expose: in_vld  in  1 and in_data  in  `IDATA_WIDTH  one result element per valid cycle from head cores.
REQ-008 SHALL expose: head_sram_wen  out  1; head_sram_waddr  out  $clog2(`HEAD_SRAM_DEPTH); head_sram_wdata  out  `MAC_MULT_NUM*`IDATA_WIDTH.
REQ-009 SHALL expose: finish  out  1  one-cycle pulse when the pass has written its last word.

Function
REQ-010 SHALL register start internally (start_q); the pass begins on the cycle start_q=1.
REQ-011 SHALL latch element target N at start_q: Q_GEN/K_GEN/V_GEN = qkv_weight_cols_per_core*`HEAD_CORE_NUM; ATT_QK = max_context_length; FFN0 = 4*qkv_weight_cols_per_core*`HEAD_CORE_NUM; all other states N=0.
REQ-012 SHALL use FSM IDLE -> COLLECT -> FLUSH -> DONE -> IDLE.
REQ-013 IDLE: on start_q with N>0 go COLLECT, clear lane counter, element counter, waddr; with N=0 pulse finish next cycle, stay IDLE.
REQ-014 COLLECT: each in_vld=1 cycle places in_data at lane L bits [L*`IDATA_WIDTH +: `IDATA_WIDTH], increments L and element count.
REQ-015 When L reaches `MAC_MULT_NUM-1 with in_vld, head_sram_wen SHALL assert next cycle for exactly one cycle with the full word; L wraps to 0.
REQ-016 waddr SHALL equal the word index (0,1,2...) at each wen and increment after it; it SHALL never wrap within a pass.
REQ-017 When element count reaches N and last word is full, go DONE; if partial, go FLUSH.
REQ-018 FLUSH: one cycle; write the partial word with unfilled lanes zero, then DONE.
REQ-019 DONE: finish=1 for one cycle, coinciding with the cycle after the last wen; return to IDLE.
REQ-020 in_vld SHALL be ignored in IDLE, FLUSH, DONE and after N elements.
REQ-021 start_q during COLLECT/FLUSH SHALL abort the pass without writing the partial word and restart at waddr 0.
REQ-022 Counters SHALL be one bit wider than $clog2 of their maximum to avoid overflow at N=max.
REQ-023 control_state_update during a pass SHALL not alter latched N.

Reset
REQ-024 On rst_n=0: FSM IDLE, finish=0, head_sram_wen=0, head_sram_waddr=0, head_sram_wdata=0, all counters and config registers 0, control_state register IDLE_STATE.
REQ-025 Reset mid-pass SHALL discard buffered lanes; no write after release until new start.

Structure
REQ-026 CONTROL_STATE, MODEL_CONFIG, `MAC_MULT_NUM, `HEAD_SRAM_DEPTH, `HEAD_CORE_NUM, `IDATA_WIDTH SHALL come from the shared package/defines; no local redefinition.
REQ-027 Lane packer (shift-in word register + lane counter) SHALL be one sub-module head_lane_packer; FSM and address logic stay in top.

Verification
REQ-028 Q_GEN, MAC_MULT_NUM=16, N=64, in_vld continuous -> 4 wen at waddr 0..3, finish 1 cycle after 4th wen.
REQ-029 ATT_QK, N=20, MAC_MULT_NUM=16 -> wen at waddr 0 full, waddr 1 lanes 0-3 data, lanes 4-15 zero; then finish.
REQ-030 in_vld gapped 1-on/2-off, N=32 -> word contents identical to continuous case; 2 wen.
REQ-031 start re-pulsed after 10 elements -> no wen for partial word; new pass writes from waddr 0.
REQ-032 PROJ state start -> no wen, finish pulse 2 cycles after start.
REQ-033 rst_n low after 8 elements then release -> all outputs 0; in_vld without start produces no wen.

Source files
------------

// File: rtl/head_sram_wr_ctrl_pkg.sv
// Shared types and sizing for the head SRAM write path: layer phases,
// model configuration and the element-target rule per phase.
package head_sram_wr_ctrl_pkg;

  localparam int IDATA_WIDTH     = 8;
  localparam int MAC_MULT_NUM    = 16;
  localparam int HEAD_CORE_NUM   = 4;
  localparam int HEAD_SRAM_DEPTH = 256;

  localparam int WORD_W = MAC_MULT_NUM * IDATA_WIDTH;
  localparam int ADDR_W = $clog2(HEAD_SRAM_DEPTH);
  localparam int LANE_W = $clog2(MAC_MULT_NUM - 1) + 1;
  localparam int COLS_W = 8;
  localparam int CTX_W  = 10;
  // Largest target is FFN0 with the widest column count.
  localparam int N_MAX  = 4 * ((1 << COLS_W) - 1) * HEAD_CORE_NUM;
  localparam int CNT_W  = $clog2(N_MAX) + 1;

  typedef enum logic [3:0] {
    IDLE_STATE = 4'd0,
    Q_GEN      = 4'd1,
    K_GEN      = 4'd2,
    V_GEN      = 4'd3,
    ATT_QK     = 4'd4,
    ATT_PV     = 4'd5,
    PROJ       = 4'd6,
    FFN0       = 4'd7,
    FFN1       = 4'd8
  } control_state_t;

  typedef struct packed {
    logic [COLS_W-1:0] qkv_weight_cols_per_core;
    logic [CTX_W-1:0]  max_context_length;
  } model_config_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_t;

  function automatic logic [CNT_W-1:0] calc_target(input control_state_t cs,
                                                   input model_config_t cfg);
    logic [CNT_W-1:0] per_pass;
    per_pass = CNT_W'(cfg.qkv_weight_cols_per_core) * CNT_W'(HEAD_CORE_NUM);
    case (cs)
      Q_GEN, K_GEN, V_GEN: calc_target = per_pass;
      ATT_QK:              calc_target = CNT_W'(cfg.max_context_length);
      FFN0:                calc_target = per_pass << 2;
      default:             calc_target = '0;
    endcase
  endfunction

endpackage

// File: rtl/head_sram_wr_ctrl_lane_packer.sv
// Packs element-wide results into SRAM-wide words; emits a registered word
// strobe when the last lane fills or when a partial word is flushed.
module head_lane_packer
  import head_sram_wr_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   flush,
  input  logic [IDATA_WIDTH-1:0] data,
  output logic                   lane_full,
  output logic                   word_vld,
  output logic [WORD_W-1:0]      word
);

  logic [WORD_W-1:0] buf_reg;
  logic [LANE_W-1:0] lane_reg;
  logic [WORD_W-1:0] merged;

  assign lane_full = (lane_reg == LANE_W'(MAC_MULT_NUM - 1));

  generate
    for (genvar gi = 0; gi < MAC_MULT_NUM; gi++) begin : g_lane
      assign merged[gi*IDATA_WIDTH +: IDATA_WIDTH] =
          (lane_reg == LANE_W'(gi)) ? data : buf_reg[gi*IDATA_WIDTH +: IDATA_WIDTH];
    end
  endgenerate

  // The buffer is cleared whenever a word leaves so unfilled lanes read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg  <= '0;
      lane_reg <= '0;
      word_vld <= 1'b0;
      word     <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        buf_reg  <= '0;
        lane_reg <= '0;
      end else if (push) begin
        if (lane_full) begin
          word     <= merged;
          word_vld <= 1'b1;
          buf_reg  <= '0;
          lane_reg <= '0;
        end else begin
          buf_reg  <= merged;
          lane_reg <= lane_reg + LANE_W'(1);
        end
      end else if (flush) begin
        word     <= buf_reg;
        word_vld <= 1'b1;
        buf_reg  <= '0;
        lane_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/head_sram_wr_ctrl.sv
// Collects head-core result elements for one layer phase and writes them to
// the head SRAM as packed words at consecutive addresses, then pulses finish.
module head_sram_wr_ctrl
  import head_sram_wr_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  control_state_t         control_state,
  input  logic                   control_state_update,
  input  logic                   model_cfg_vld,
  input  model_config_t          model_cfg,
  input  logic                   start,
  input  logic                   in_vld,
  input  logic [IDATA_WIDTH-1:0] in_data,
  output logic                   head_sram_wen,
  output logic [ADDR_W-1:0]      head_sram_waddr,
  output logic [WORD_W-1:0]      head_sram_wdata,
  output logic                   finish
);

  control_state_t   cs_reg;
  model_config_t    cfg_reg;
  logic             start_q;
  wr_state_t        state_reg, state_next;
  logic [CNT_W-1:0] n_reg, n_calc, elem_cnt_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic             finish_reg;

  logic restart, push, last_push, flush_word, finish_next, lane_full;

  assign n_calc          = calc_target(cs_reg, cfg_reg);
  assign head_sram_waddr = waddr_reg;
  assign finish          = finish_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_COLLECT, ST_FLUSH: begin
        if (restart) begin
          state_next = (n_calc != '0) ? ST_COLLECT : ST_IDLE;
        end else if (state_reg == ST_FLUSH) begin
          state_next = ST_DONE;
        end else if (last_push) begin
          state_next = lane_full ? ST_DONE : ST_FLUSH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A start arriving mid-pass wins over data on the same cycle, so the
  // aborted partial word is never written.
  always_comb begin
    restart     = start_q && (state_reg != ST_DONE);
    push        = (state_reg == ST_COLLECT) && !start_q && in_vld;
    last_push   = push && (elem_cnt_reg == n_reg - CNT_W'(1));
    flush_word  = (state_reg == ST_FLUSH) && !start_q;
    finish_next = (state_reg == ST_DONE) || (restart && (n_calc == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_reg       <= IDLE_STATE;
      cfg_reg      <= '0;
      start_q      <= 1'b0;
      n_reg        <= '0;
      elem_cnt_reg <= '0;
      waddr_reg    <= '0;
      finish_reg   <= 1'b0;
    end else begin
      if (control_state_update) cs_reg <= control_state;
      if (model_cfg_vld) cfg_reg <= model_cfg;
      start_q    <= start;
      finish_reg <= finish_next;
      if (restart) begin
        n_reg        <= n_calc;
        elem_cnt_reg <= '0;
        waddr_reg    <= '0;
      end else begin
        if (push) elem_cnt_reg <= elem_cnt_reg + CNT_W'(1);
        if (head_sram_wen) waddr_reg <= waddr_reg + ADDR_W'(1);
      end
    end
  end

  head_lane_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (restart),
    .push      (push),
    .flush     (flush_word),
    .data      (in_data),
    .lane_full (lane_full),
    .word_vld  (head_sram_wen),
    .word      (head_sram_wdata)
  );

endmodule
